// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizes a raw bouncing key, qualifies press
// and release with a shared debounce timer, flags long holds, and keeps a
// press-count mode for the downstream LED stage.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | key released and qualified, waiting for activity
//   PRESS_DEB | key seen pressed, counting debounce before accepting
//   HELD      | press accepted, hold timer running toward long press
//   REL_DEB   | key seen released, counting debounce before accepting
module key_debounce #(
  parameter int CNT_DEB        = 20,
  parameter int CNT_LONG       = 1000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_state,
  output logic       key_press,
  output logic       key_release,
  output logic       key_long,
  output logic [1:0] mode
);

  localparam int DEB_W  = (CNT_DEB > 1) ? $clog2(CNT_DEB) : 1;
  localparam int HOLD_W = (CNT_LONG > 0) ? $clog2(CNT_LONG + 1) : 1;

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(CNT_DEB - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(CNT_LONG);
  localparam logic              IDLE_LVL = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic              act;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0] hold_inc;
  logic              press_d, release_d, long_d;
  logic              key_state_q, key_press_q, key_release_q, key_long_q;
  logic [1:0]        mode_q;

  // Two-flop synchronizer; resets to the released level so no false press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign act      = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign hold_inc = hold_cnt_q + HOLD_W'(1);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state, counter updates and event strobes.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d   = PRESS_DEB;
          deb_cnt_d = '0;
        end
      end
      PRESS_DEB: begin
        if (!act) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HELD: begin
        if (!act) begin
          state_d   = REL_DEB;
          deb_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          // Saturation keeps long from re-firing after an absorbed bounce.
          hold_cnt_d = hold_inc;
          long_d     = (hold_inc == HOLD_MAX);
        end
      end
      REL_DEB: begin
        if (act) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          release_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs; long press clears mode ahead of any increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_long_q    <= 1'b0;
      mode_q        <= 2'd0;
    end else begin
      key_press_q   <= press_d;
      key_release_q <= release_d;
      key_long_q    <= long_d;
      if (press_d) begin
        key_state_q <= 1'b1;
      end else if (release_d) begin
        key_state_q <= 1'b0;
      end
      if (long_d) begin
        mode_q <= 2'd0;
      end else if (press_d) begin
        mode_q <= mode_q + 2'd1;
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign key_long    = key_long_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with CNT_DEB=4, CNT_LONG=10, active-low key.
// Reference model tracks a debounced level plus the length of the current
// run of disagreeing samples, and counts qualified held time.
module tb_key_debounce;

  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       key_state, key_press, key_release, key_long;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  // model state
  logic h1, h2;
  logic deb;
  int   run, hold, m_mode;
  logic m_press, m_rel, m_long;

  key_debounce #(.CNT_DEB(D), .CNT_LONG(L), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .mode(mode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] dut_v();
    return {key_state, key_press, key_release, key_long, mode};
  endfunction

  function automatic logic [5:0] exp_v();
    logic [1:0] mm;
    mm = m_mode[1:0];
    return {deb, m_press, m_rel, m_long, mm};
  endfunction

  // Behavioural reference: the level flips once the raw key (seen two edges
  // late) has disagreed with it for D+1 consecutive edges.
  task automatic model_edge(input logic k, input logic r);
    logic act, old_deb;
    int   old_run;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (r) begin
      h1 = 1'b1; h2 = 1'b1; deb = 1'b0;
      run = 0; hold = 0; m_mode = 0;
    end else begin
      act = ~h2;
      h2  = h1;
      h1  = k;
      old_deb = deb;
      old_run = run;
      if (old_deb && old_run == 0 && act && hold < L) begin
        hold = hold + 1;
        if (hold == L) begin
          m_long = 1'b1;
          m_mode = 0;
        end
      end
      if (act != old_deb) begin
        run = old_run + 1;
        if (run == D + 1) begin
          run = 0;
          deb = ~old_deb;
          if (deb) begin
            m_press = 1'b1;
            m_mode  = (m_mode + 1) % 4;
          end else begin
            m_rel = 1'b1;
            hold  = 0;
          end
        end
      end else begin
        run = 0;
      end
    end
  endtask

  task automatic tick(input logic k, input logic r);
    @(negedge clk);
    key_in = k;
    rst    = r;
    @(posedge clk);
    model_edge(k, r);
    #1;
  endtask

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      total++;
      if (dut_v() !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=%b", i, dut_v(), 6'b0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      total++;
      if (dut_v() !== exp_v()) begin
        bad++;
        $display("FAIL reset_settle cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
      end
    end
  endtask

  task automatic test_clean_press;
    int press_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (dut_v() !== exp_v()) begin
        bad++;
        $display("FAIL clean_press cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
      end
      if (key_press === 1'b1 && press_at < 0) press_at = i;
    end
    total++;
    if (press_at != 6) begin
      bad++;
      $display("FAIL clean_press_latency got=%0d want=6", press_at);
    end
    total++;
    if ({key_state, mode} !== 3'b101) begin
      bad++;
      $display("FAIL clean_press_state got=%b want=101", {key_state, mode});
    end
    go_idle(12);
  endtask

  task automatic test_bounce_press;
    int press_at = -1;
    int presses  = 0;
    for (int i = 0; i < 15; i++) begin
      tick((i == 2) ? 1'b1 : 1'b0, 1'b0);
      total++;
      if (dut_v() !== exp_v()) begin
        bad++;
        $display("FAIL bounce_press cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
      end
      if (key_press === 1'b1) begin
        presses++;
        if (press_at < 0) press_at = i;
      end
    end
    total++;
    if (presses != 1 || press_at != 9) begin
      bad++;
      $display("FAIL bounce_press_count got=%0d@%0d want=1@9", presses, press_at);
    end
    go_idle(12);
  endtask

  task automatic test_long_press;
    int press_at = -1;
    int long_at  = -1;
    int longs    = 0;
    for (int i = 0; i < 27; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (dut_v() !== exp_v()) begin
        bad++;
        $display("FAIL long_press cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
      end
      if (key_press === 1'b1 && press_at < 0) press_at = i;
      if (key_long === 1'b1) begin
        longs++;
        long_at = i;
      end
    end
    total++;
    if (longs != 1 || long_at - press_at != 10) begin
      bad++;
      $display("FAIL long_press_pulse got=%0d@+%0d want=1@+10", longs, long_at - press_at);
    end
    total++;
    if ({key_state, mode} !== 3'b100) begin
      bad++;
      $display("FAIL long_press_mode got=%b want=100", {key_state, mode});
    end
  endtask

  // Continues from the held key left by test_long_press.
  task automatic test_release_bounce;
    int rel_at = -1;
    int rels = 0, presses = 0, longs = 0;
    for (int i = 0; i < 16; i++) begin
      tick((i == 2) ? 1'b0 : 1'b1, 1'b0);
      total++;
      if (dut_v() !== exp_v()) begin
        bad++;
        $display("FAIL release_bounce cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
      end
      if (key_release === 1'b1) begin
        rels++;
        if (rel_at < 0) rel_at = i;
        total++;
        if (key_state !== 1'b0) begin
          bad++;
          $display("FAIL release_state got=%b want=0", key_state);
        end
      end
      if (key_press === 1'b1) presses++;
      if (key_long === 1'b1) longs++;
    end
    total++;
    if (rels != 1 || rel_at != 9 || presses != 0 || longs != 0) begin
      bad++;
      $display("FAIL release_bounce_count got=rel%0d@%0d press%0d long%0d want=rel1@9 press0 long0",
               rels, rel_at, presses, longs);
    end
  endtask

  task automatic test_wrap;
    int want [4] = '{1, 2, 3, 0};
    int seen;
    tick(1'b1, 1'b1);
    go_idle(4);
    for (int p = 0; p < 4; p++) begin
      seen = -1;
      for (int i = 0; i < 16; i++) begin
        tick((i < 8) ? 1'b0 : 1'b1, 1'b0);
        total++;
        if (dut_v() !== exp_v()) begin
          bad++;
          $display("FAIL wrap cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
        end
        if (key_press === 1'b1) seen = int'(mode);
      end
      total++;
      if (seen != want[p]) begin
        bad++;
        $display("FAIL wrap_mode press=%0d got=%0d want=%0d", p, seen, want[p]);
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    int press_at = -1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    total++;
    if (dut_v() !== 6'b0) begin
      bad++;
      $display("FAIL midhold_reset got=%b want=%b", dut_v(), 6'b0);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0);
      total++;
      if (dut_v() !== exp_v()) begin
        bad++;
        $display("FAIL midhold_requal cyc=%0d got=%b want=%b", i, dut_v(), exp_v());
      end
      if (key_press === 1'b1 && press_at < 0) press_at = i;
    end
    total++;
    if (press_at != 6) begin
      bad++;
      $display("FAIL midhold_latency got=%0d want=6", press_at);
    end
    go_idle(12);
  endtask

  task automatic test_random;
    logic k, r;
    int   len;
    for (int s = 0; s < 250; s++) begin
      k   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, 199) == 0);
        tick(k, r);
        total++;
        if (dut_v() !== exp_v()) begin
          bad++;
          $display("FAIL random seg=%0d cyc=%0d got=%b want=%b", s, i, dut_v(), exp_v());
        end
        total++;
        if (int'(key_press) + int'(key_release) + int'(key_long) > 1) begin
          bad++;
          $display("FAIL random_exclusive got=%b want=at most one pulse",
                   {key_press, key_release, key_long});
        end
      end
    end
  endtask

  initial begin
    key_in = 1'b1;
    rst    = 1'b1;
    model_edge(1'b1, 1'b1);
    test_reset();
    test_clean_press();
    test_bounce_press();
    test_long_press();
    test_release_bounce();
    test_wrap();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CNT_DEB, 20, debounce qualification time in clk cycles (testbench uses 4).
- CNT_LONG, 1000, long-press threshold in clk cycles spent in HELD (testbench uses 10).
- KEY_ACTIVE_LOW, 1, 1 = key_in low means pressed; 0 = high means pressed.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  1  raw asynchronous, bouncing push-button.
- key_state  output  1  debounced level; 1 = pressed.
- key_press  output  1  one-cycle pulse on qualified press.
- key_release  output  1  one-cycle pulse on qualified release.
- key_long  output  1  one-cycle pulse when the hold reaches CNT_LONG.
- mode  output  2  press-count mode select for the downstream LED stage.

Function
REQ-003 key_in SHALL pass through a 2-flop synchronizer, followed by polarity normalisation per KEY_ACTIVE_LOW, giving act (1 = pressed).
REQ-004 The FSM SHALL have exactly four states: IDLE, PRESS_DEB, HELD and REL_DEB. It SHALL use one debounce counter of width clog2(CNT_DEB) and one hold counter of width clog2(CNT_LONG+1).
REQ-005 IDLE: when act=1, go to PRESS_DEB and clear the debounce counter; otherwise stay in IDLE.
REQ-006 PRESS_DEB: when act=0, return to IDLE with no pulse. When act=1, increment the debounce counter. When the counter equals CNT_DEB-1 with act=1, go to HELD.
REQ-007 HELD: when act=0, go to REL_DEB and clear the debounce counter. When act=1, increment the hold counter, saturating at CNT_LONG.
REQ-008 REL_DEB: when act=1, return to HELD. This produces no key_press and does not clear the hold counter. When act=0, increment the debounce counter. When the counter equals CNT_DEB-1 with act=0, go to IDLE and clear the hold counter.
REQ-009 Timing of key_press: take edge 0 as the first rising edge at which key_in is sampled pressed, with the input stable thereafter. key_press SHALL then be high only in the cycle following edge CNT_DEB+2.
REQ-010 key_press SHALL be high only in the cycle after the PRESS_DEB->HELD transition. key_release SHALL be high only in the cycle after the REL_DEB->IDLE transition.
REQ-011 key_long SHALL pulse once per press, in the cycle after the hold counter first reaches CNT_LONG. Release bounces absorbed by REL_DEB SHALL NOT re-trigger it.
REQ-012 key_state SHALL be 1 from the key_press cycle through the cycle before key_release. It SHALL be 0 otherwise.
REQ-013 mode SHALL increment modulo 4 on each key_press, wrapping 3->0.
REQ-014 If key_long fires, mode SHALL be set to 0, taking priority over any increment in the same cycle.
REQ-015 key_press, key_release and key_long SHALL be mutually exclusive in any cycle. All outputs SHALL be registered.
REQ-016 Glitches on key_in shorter than CNT_DEB cycles SHALL produce no output change.

Reset
REQ-017 While rst=1 at a rising edge, the following SHALL occur:
- state = IDLE
- both counters = 0
- synchronizer flops = inactive level
- key_state = 0, key_press = 0, key_release = 0, key_long = 0, mode = 0
REQ-018 Reset asserted mid-press SHALL abort without any pulse. After release of rst with the key still held, a new full PRESS_DEB qualification SHALL be required before key_press.

Verification
(All scenarios use CNT_DEB=4, CNT_LONG=10, KEY_ACTIVE_LOW=1.)
REQ-019 Clean press: key_in driven low at edge 0 and held -> key_press high exactly in the cycle after edge 6; key_state=1; mode goes 0->1.
REQ-020 Bounce: key_in low for 2 cycles, high for 1, then low stably -> exactly one key_press; no pulse during the bounce.
REQ-021 Long press: hold 20 cycles after key_press -> exactly one key_long, 10 cycles after the key_press cycle; mode forced to 0; no second key_long.
REQ-022 Release with bounce: high 2 cycles, low 1, then high stably -> exactly one key_release; key_state falls with it; no extra key_press.
REQ-023 Wrap: four clean short presses from reset -> mode sequence 1,2,3,0.
REQ-024 Reset mid-hold: rst pulsed for 1 cycle while in HELD, with the key kept low -> all outputs 0 and mode=0; key_press reasserts 6 cycles after rst deasserts.
